// File: rtl/rtc_prog_clock_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rtc_prog_clock_pkg
// Description : Shared constants for the PDP-8e programmable real-time clock
//               (device 13). Holds the major-state codes, the IOT opcodes
//               and the mode/rate field encodings of the enable register.
// Revision    : 1.0 - initial release
// ============================================================================
package rtc_prog_clock_pkg;

  // Major-state codes driven by the CPU sequencer
  localparam logic [4:0] F0 = 5'd0;
  localparam logic [4:0] F1 = 5'd1;
  localparam logic [4:0] F2 = 5'd2;
  localparam logic [4:0] F3 = 5'd3;

  // IOT opcodes for device 13, plus the processor-wide CAF
  localparam logic [11:0] IOT_CLZE = 12'o6130;
  localparam logic [11:0] IOT_CLSK = 12'o6131;
  localparam logic [11:0] IOT_CLDE = 12'o6132;
  localparam logic [11:0] IOT_CLAB = 12'o6133;
  localparam logic [11:0] IOT_CLEN = 12'o6134;
  localparam logic [11:0] IOT_CLSA = 12'o6135;
  localparam logic [11:0] IOT_CLBA = 12'o6136;
  localparam logic [11:0] IOT_CLCA = 12'o6137;
  localparam logic [11:0] IOT_CAF  = 12'o6007;

  // ENA1:2 counting mode
  typedef enum logic [1:0] {
    MODE_STOP    = 2'b00,
    MODE_FREE    = 2'b01,
    MODE_RELOAD  = 2'b10,
    MODE_ONESHOT = 2'b11
  } rtc_mode_e;

  // ENA3:4 tick rate
  typedef enum logic [1:0] {
    RATE_100HZ  = 2'b00,
    RATE_1KHZ   = 2'b01,
    RATE_10KHZ  = 2'b10,
    RATE_100KHZ = 2'b11
  } rtc_rate_e;

endpackage : rtc_prog_clock_pkg
`default_nettype wire

// File: rtl/rtc_prog_clock_prescaler.sv
`default_nettype none
// ============================================================================
// Module      : rtc_prescaler
// Description : Divides clk down to the selected tick rate. Counts
//               0..div-1 while run is high and emits a one-cycle tick on
//               the terminal count. Divisor = CLK_FREQ/rate, floored and
//               clamped to at least 1 (div=1 ticks every cycle).
// Ports       : clk, reset (async, active-high)
//               rate[1:0]  rate select (rtc_rate_e)
//               run        count enable (mode != stop)
//               restart    synchronously return the count to 0
//               tick       combinational one-cycle tick at div-1
// Revision    : 1.0 - initial release
// ============================================================================
module rtc_prescaler
  import rtc_prog_clock_pkg::*;
#(
  parameter int CLK_FREQ = 50_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] rate,
  input  logic       run,
  input  logic       restart,
  output logic       tick
);

  localparam int DIV_100HZ  = (CLK_FREQ / 100)    < 1 ? 1 : (CLK_FREQ / 100);
  localparam int DIV_1KHZ   = (CLK_FREQ / 1000)   < 1 ? 1 : (CLK_FREQ / 1000);
  localparam int DIV_10KHZ  = (CLK_FREQ / 10000)  < 1 ? 1 : (CLK_FREQ / 10000);
  localparam int DIV_100KHZ = (CLK_FREQ / 100000) < 1 ? 1 : (CLK_FREQ / 100000);
  // The 100 Hz divisor is always the largest, so it sizes the counter
  localparam int CW = (DIV_100HZ > 1) ? $clog2(DIV_100HZ) : 1;

  logic [CW-1:0] cnt_q, cnt_d, last;

  always_comb begin
    case (rate)
      RATE_100HZ:  last = CW'(DIV_100HZ - 1);
      RATE_1KHZ:   last = CW'(DIV_1KHZ - 1);
      RATE_10KHZ:  last = CW'(DIV_10KHZ - 1);
      default:     last = CW'(DIV_100KHZ - 1);
    endcase
  end

  assign tick = run && (cnt_q == last);

  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (restart || !run || tick) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule : rtc_prescaler
`default_nettype wire

// File: rtl/rtc_prog_clock.sv
`default_nettype none
// ============================================================================
// Module      : rtc_prog_clock
// Description : DK8-EP-style programmable real-time clock on the PDP-8e IOT
//               bus. 12-bit tick counter with preset buffer, free-run /
//               reload / one-shot modes, overflow flag with skip and
//               interrupt.
// Ports       : clk, reset (async, active-high)
//               instruction[0:11] current IR      state[4:0] major state
//               clear  sync CAF/console clear     UF user-mode flag
//               ac[0:11] accumulator              dev_ac[0:11] data to AC
//               ac_load  one-cycle AC load strobe skip, interrupt (registered)
// Revision    : 1.0 - initial release
// ============================================================================
module rtc_prog_clock
  import rtc_prog_clock_pkg::*;
#(
  parameter int         CLK_FREQ = 50_000_000,
  parameter logic [5:0] DEV_CODE = 6'o13
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [0:11] instruction,
  input  logic [4:0]  state,
  input  logic        clear,
  input  logic        UF,
  input  logic [0:11] ac,
  output logic [0:11] dev_ac,
  output logic        ac_load,
  output logic        skip,
  output logic        interrupt
);

  logic [0:11] counter_q, counter_d;
  logic [0:11] buffer_q, buffer_d;
  logic [0:4]  ena_q, ena_d;        // ENA5 is reserved and never stored
  logic        flag_q, flag_d;
  logic        overrun_q, overrun_d;
  logic [0:11] dev_ac_q, dev_ac_d;
  logic        ac_load_q, ac_load_d;
  logic        skip_q, skip_d;
  logic        interrupt_q, interrupt_d;

  // IOT decode
  logic       iot_cycle, sel, caf, do_clear;
  logic [2:0] op;
  logic       is_clze, is_clsk, is_clde, is_clab, is_clen, is_clsa, is_clba, is_clca;

  assign iot_cycle = (state == F1) && !UF;
  assign sel       = iot_cycle && (instruction[0:8] == {3'o6, DEV_CODE});
  assign op        = instruction[9:11];
  assign caf       = iot_cycle && (instruction == IOT_CAF);
  assign do_clear  = clear || caf;

  assign is_clze = sel && (op == IOT_CLZE[2:0]);
  assign is_clsk = sel && (op == IOT_CLSK[2:0]);
  assign is_clde = sel && (op == IOT_CLDE[2:0]);
  assign is_clab = sel && (op == IOT_CLAB[2:0]);
  assign is_clen = sel && (op == IOT_CLEN[2:0]);
  assign is_clsa = sel && (op == IOT_CLSA[2:0]);
  assign is_clba = sel && (op == IOT_CLBA[2:0]);
  assign is_clca = sel && (op == IOT_CLCA[2:0]);

  // Enable-register value an IOT would write this cycle
  logic [0:4] ena_iot;
  logic       ena_write;
  assign ena_write = is_clze || is_clde || is_clen;

  always_comb begin
    ena_iot = ena_q;
    if (is_clze) begin
      ena_iot = ena_q & ~ac[0:4];
    end else if (is_clde) begin
      ena_iot = ena_q | ac[0:4];
    end else if (is_clen) begin
      ena_iot = ac[0:4];
    end
  end

  logic [1:0] mode_q;
  logic       tick, tick_cnt, ovf;
  assign mode_q = ena_q[1:2];

  rtc_prescaler #(
    .CLK_FREQ (CLK_FREQ)
  ) u_prescaler (
    .clk     (clk),
    .reset   (reset),
    .rate    (ena_q[3:4]),
    .run     (mode_q != MODE_STOP),
    .restart (ena_write || do_clear),
    .tick    (tick)
  );

  // A tick is dropped when an ENA write stops the clock in the same cycle,
  // and when CLAB loads the counter (the load takes priority).
  assign tick_cnt = tick && !(ena_write && (ena_iot[1:2] == MODE_STOP)) && !is_clab;
  assign ovf      = tick_cnt && (counter_q == 12'o7777);

  always_comb begin
    counter_d   = counter_q;
    buffer_d    = buffer_q;
    ena_d       = ena_q;
    flag_d      = flag_q;
    overrun_d   = overrun_q;
    skip_d      = skip_q;
    interrupt_d = flag_q && ena_q[0];
    dev_ac_d    = '0;
    ac_load_d   = 1'b0;
    if (do_clear) begin
      counter_d   = '0;
      buffer_d    = '0;
      ena_d       = '0;
      flag_d      = 1'b0;
      overrun_d   = 1'b0;
      skip_d      = 1'b0;
      interrupt_d = 1'b0;
    end else begin
      if (is_clab) begin
        counter_d = ac;
        buffer_d  = ac;
      end else if (tick_cnt) begin
        if (ovf) begin
          counter_d = (mode_q == MODE_FREE) ? 12'o0000 : buffer_q;
        end else begin
          counter_d = counter_q + 12'd1;
        end
      end

      if (ena_write) begin
        ena_d = ena_iot;
      end else if (ovf && (mode_q == MODE_ONESHOT)) begin
        ena_d[1:2] = MODE_STOP;
      end

      // CLSK clears flag/overrun, but a coincident overflow still sets flag
      if (is_clsk) begin
        flag_d    = 1'b0;
        overrun_d = 1'b0;
      end
      if (ovf) begin
        flag_d = 1'b1;
        if (!is_clsk) begin
          overrun_d = overrun_q || flag_q;
        end
      end

      if (sel) begin
        skip_d = is_clsk && flag_q;
      end

      if (is_clsa) begin
        dev_ac_d  = {flag_q, overrun_q, ena_q, 5'b00000};
        ac_load_d = 1'b1;
      end else if (is_clba) begin
        dev_ac_d  = buffer_q;
        ac_load_d = 1'b1;
      end else if (is_clca) begin
        dev_ac_d  = counter_q;
        ac_load_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      counter_q   <= '0;
      buffer_q    <= '0;
      ena_q       <= '0;
      flag_q      <= 1'b0;
      overrun_q   <= 1'b0;
      dev_ac_q    <= '0;
      ac_load_q   <= 1'b0;
      skip_q      <= 1'b0;
      interrupt_q <= 1'b0;
    end else begin
      counter_q   <= counter_d;
      buffer_q    <= buffer_d;
      ena_q       <= ena_d;
      flag_q      <= flag_d;
      overrun_q   <= overrun_d;
      dev_ac_q    <= dev_ac_d;
      ac_load_q   <= ac_load_d;
      skip_q      <= skip_d;
      interrupt_q <= interrupt_d;
    end
  end

  assign dev_ac    = dev_ac_q;
  assign ac_load   = ac_load_q;
  assign skip      = skip_q;
  assign interrupt = interrupt_q;

endmodule : rtc_prog_clock
`default_nettype wire

// File: tb/tb_rtc_prog_clock.sv
`default_nettype none
// ============================================================================
// Module      : tb_rtc_prog_clock
// Description : Self-checking bench for rtc_prog_clock with CLK_FREQ=1000,
//               so the 10k/100k rates divide to 1 (tick every cycle).
//               Read IOTs push the expected AC value to a scoreboard queue;
//               a monitor pops and compares on each ac_load strobe.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rtc_prog_clock;
  import rtc_prog_clock_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [0:11] instruction;
  logic [4:0]  state;
  logic        clear;
  logic        UF;
  logic [0:11] ac;
  logic [0:11] dev_ac;
  logic        ac_load;
  logic        skip;
  logic        interrupt;

  int total = 0;
  int bad   = 0;
  logic [11:0] sb[$];

  rtc_prog_clock #(
    .CLK_FREQ (1000),
    .DEV_CODE (6'o13)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .instruction (instruction),
    .state       (state),
    .clear       (clear),
    .UF          (UF),
    .ac          (ac),
    .dev_ac      (dev_ac),
    .ac_load     (ac_load),
    .skip        (skip),
    .interrupt   (interrupt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [11:0] got, input logic [11:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%o exp=%o at %0t", tag, got, exp, $time);
    end
  endtask

  // Scoreboard consumer: every ac_load must match the oldest pending read
  always @(negedge clk) begin
    if (ac_load === 1'b1) begin
      if (sb.size() == 0) begin
        chk("ac_load_unexpected", {11'd0, ac_load}, 12'd0);
      end else begin
        chk("rd_dev_ac", dev_ac, sb.pop_front());
      end
    end
  end

  // One IOT in F1; returns 1ns after the edge that executes it
  task automatic iot(input logic [11:0] code, input logic [11:0] acv);
    @(negedge clk);
    instruction = code;
    ac          = acv;
    state       = F1;
    @(posedge clk);
    #1;
    state       = F2;
    instruction = 12'o0000;
    ac          = 12'o0000;
  endtask

  task automatic rd(input logic [11:0] code, input logic [11:0] exp);
    sb.push_back(exp);
    iot(code, 12'o0000);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
  endtask

  // Running, flag pending, interrupt enabled, skip set, counter near 0042
  task automatic arm();
    iot(IOT_CLEN, 12'o5600);
    iot(IOT_CLAB, 12'o7777);
    idle(1);
    iot(IOT_CLAB, 12'o0042);
    iot(IOT_CLSK, 12'o0000);
    chk("arm_skip", {11'd0, skip}, 12'd1);
    chk("arm_int", {11'd0, interrupt}, 12'd1);
  endtask

  initial begin
    reset = 1'b1; clear = 1'b0; UF = 1'b0;
    instruction = 12'o0000; ac = 12'o0000; state = F0;
    idle(2);
    @(negedge clk) reset = 1'b0;
    #1;
    chk("rst_dev_ac", dev_ac, 12'o0000);
    chk("rst_ac_load", {11'd0, ac_load}, 12'd0);
    chk("rst_skip", {11'd0, skip}, 12'd0);
    chk("rst_int", {11'd0, interrupt}, 12'd0);
    rd(IOT_CLCA, 12'o0000);

    // Preset, then free-run at one tick per cycle
    iot(IOT_CLAB, 12'o7775);
    rd(IOT_CLCA, 12'o7775);
    rd(IOT_CLBA, 12'o7775);
    iot(IOT_CLEN, 12'o1600);
    idle(3);
    rd(IOT_CLCA, 12'o0000);
    rd(IOT_CLSA, 12'o4340);
    chk("free_int_off", {11'd0, interrupt}, 12'd0);
    iot(IOT_CLDE, 12'o4000);
    chk("int_latency", {11'd0, interrupt}, 12'd0);
    idle(1); #1;
    chk("int_on", {11'd0, interrupt}, 12'd1);

    // CLSK: skip on flag, holds until next F1, second CLSK no skip
    iot(IOT_CLSK, 12'o0000);
    chk("clsk_skip", {11'd0, skip}, 12'd1);
    idle(1); #1;
    chk("skip_hold", {11'd0, skip}, 12'd1);
    chk("int_after_clsk", {11'd0, interrupt}, 12'd0);
    iot(IOT_CLSK, 12'o0000);
    chk("clsk2_skip", {11'd0, skip}, 12'd0);

    // Reload mode, buffer 7770: overflow every 8 ticks, overrun on second
    iot(IOT_CLZE, 12'o3000);
    iot(IOT_CLAB, 12'o7770);
    iot(IOT_CLEN, 12'o2600);
    idle(7);
    rd(IOT_CLCA, 12'o7777);
    rd(IOT_CLCA, 12'o7770);
    rd(IOT_CLSA, 12'o4540);
    idle(6);
    rd(IOT_CLSA, 12'o6540);
    iot(IOT_CLSK, 12'o0000);
    chk("ovr_clsk_skip", {11'd0, skip}, 12'd1);
    rd(IOT_CLSA, 12'o0540);
    iot(IOT_CLZE, 12'o3000);

    // One-shot: one overflow, mode returns to stop, counter holds
    iot(IOT_CLAB, 12'o7776);
    iot(IOT_CLEN, 12'o3600);
    idle(4);
    rd(IOT_CLSA, 12'o4140);
    rd(IOT_CLCA, 12'o7776);
    idle(5);
    rd(IOT_CLCA, 12'o7776);

    // User mode: IOTs ignored, skip neither set nor cleared
    UF = 1'b1;
    iot(IOT_CLSK, 12'o0000);
    chk("uf_noskip", {11'd0, skip}, 12'd0);
    UF = 1'b0;
    iot(IOT_CLSK, 12'o0000);
    chk("flag_kept_skip", {11'd0, skip}, 12'd1);
    UF = 1'b1;
    iot(IOT_CLCA, 12'o0000);
    chk("uf_skip_hold", {11'd0, skip}, 12'd1);
    chk("uf_no_load", {11'd0, ac_load}, 12'd0);
    UF = 1'b0;

    // Collisions
    iot(IOT_CLEN, 12'o1600);
    iot(IOT_CLAB, 12'o1234);
    rd(IOT_CLCA, 12'o1234);
    rd(IOT_CLCA, 12'o1235);
    iot(IOT_CLAB, 12'o7776);
    rd(IOT_CLCA, 12'o7776);
    iot(IOT_CLSK, 12'o0000);
    chk("clsk_ovf_skip", {11'd0, skip}, 12'd0);
    rd(IOT_CLSA, 12'o4340);
    iot(IOT_CLAB, 12'o0100);
    iot(IOT_CLZE, 12'o3000);
    rd(IOT_CLCA, 12'o0100);
    idle(2);
    rd(IOT_CLCA, 12'o0100);

    // Async reset mid-count
    arm();
    reset = 1'b1;
    #1;
    chk("areset_skip", {11'd0, skip}, 12'd0);
    chk("areset_int", {11'd0, interrupt}, 12'd0);
    chk("areset_load", {11'd0, ac_load}, 12'd0);
    chk("areset_dev_ac", dev_ac, 12'o0000);
    @(negedge clk) reset = 1'b0;
    rd(IOT_CLCA, 12'o0000);
    rd(IOT_CLSA, 12'o0000);

    // Synchronous clear
    arm();
    @(negedge clk) clear = 1'b1;
    chk("clear_not_yet", {11'd0, skip}, 12'd1);
    @(posedge clk); #1;
    clear = 1'b0;
    chk("clear_skip", {11'd0, skip}, 12'd0);
    chk("clear_int", {11'd0, interrupt}, 12'd0);
    rd(IOT_CLCA, 12'o0000);
    rd(IOT_CLSA, 12'o0000);

    // CAF
    arm();
    iot(IOT_CAF, 12'o0000);
    chk("caf_skip", {11'd0, skip}, 12'd0);
    chk("caf_int", {11'd0, interrupt}, 12'd0);
    rd(IOT_CLCA, 12'o0000);
    rd(IOT_CLBA, 12'o0000);
    rd(IOT_CLSA, 12'o0000);

    idle(3);
    chk("sb_drained", 12'(sb.size()), 12'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_rtc_prog_clock
`default_nettype wire
